// File: rtl/hazard_control_unit.sv
// Hazard control for a classic 5-stage MIPS pipeline: load-use stall, redirect flush
// and EX-stage operand forwarding, driven from a private shadow copy of EX/MEM/WB.
module hazard_control_unit #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [4:0]             id_rs,
    input  logic [4:0]             id_rt,
    input  logic                   id_use_rs,
    input  logic                   id_use_rt,
    input  logic                   id_reg_write,
    input  logic [4:0]             id_write_reg,
    input  logic                   id_mem_read,
    input  logic                   ex_redirect,
    output logic                   pc_write,
    output logic                   if_id_write,
    output logic                   if_id_flush,
    output logic                   id_ex_bubble,
    output logic [1:0]             fwd_a,
    output logic [1:0]             fwd_b,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [4:0] write_reg;
        logic       mem_read;
    } dst_t;

    typedef struct packed {
        dst_t       dst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
    } ex_t;

    ex_t                    ex_q, ex_d;
    dst_t                   mem_q, wb_q;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
    logic                   load_use, redirect, stall;
    logic                   unused_wb_mem_read;

    // $0 is hard-wired, so a write to it is never a real producer.
    function automatic logic is_src(input dst_t s);
        return s.valid & s.reg_write & (s.write_reg != 5'd0);
    endfunction

    // A load sitting in MEM has no data yet; its value is picked up from WB a cycle later.
    function automatic logic [1:0] fwd_sel(input dst_t mem_s, input dst_t wb_s,
                                           input logic [4:0] r, input logic use_r);
        logic [1:0] sel;
        sel = 2'b00;
        if (use_r && is_src(mem_s) && !mem_s.mem_read && (mem_s.write_reg == r))
            sel = 2'b10;
        else if (use_r && is_src(wb_s) && (wb_s.write_reg == r))
            sel = 2'b01;
        return sel;
    endfunction

    assign unused_wb_mem_read = wb_q.mem_read;

    always_comb begin
        load_use = reset & id_valid & is_src(ex_q.dst) & ex_q.dst.mem_read &
                   ((id_use_rs & (ex_q.dst.write_reg == id_rs)) |
                    (id_use_rt & (ex_q.dst.write_reg == id_rt)));
        redirect = reset & ex_redirect;
        stall    = load_use & ~redirect;

        pc_write     = ~stall;
        if_id_write  = ~stall;
        if_id_flush  = redirect;
        id_ex_bubble = stall | redirect;
        fwd_a        = fwd_sel(mem_q, wb_q, ex_q.rs, ex_q.use_rs);
        fwd_b        = fwd_sel(mem_q, wb_q, ex_q.rt, ex_q.use_rt);
    end

    always_comb begin
        ex_d               = '0;
        ex_d.dst.valid     = id_valid;
        ex_d.dst.reg_write = id_reg_write;
        ex_d.dst.write_reg = id_write_reg;
        ex_d.dst.mem_read  = id_mem_read;
        ex_d.rs            = id_rs;
        ex_d.rt            = id_rt;
        ex_d.use_rs        = id_use_rs;
        ex_d.use_rt        = id_use_rt;
        if (id_ex_bubble)
            ex_d = '0;

        cnt_d = cnt_q;
        if (stall && (cnt_q != {STALL_CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q.dst;
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed pipeline scenarios plus randomized traffic
// checked against a record-per-stage model of the pipeline rules.
module tb_hazard_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read, ex_redirect;
    logic [4:0]  id_rs, id_rt, id_write_reg;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_count;
    logic        pc_write2, if_id_write2, if_id_flush2, id_ex_bubble2;
    logic [1:0]  fwd_a2, fwd_b2;
    logic [1:0]  stall_count2;
    logic [7:0]  obs, obs2;

    always #5 clk = ~clk;

    hazard_control_unit u_dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write),
        .id_write_reg(id_write_reg), .id_mem_read(id_mem_read), .ex_redirect(ex_redirect),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
    );

    hazard_control_unit #(.STALL_CNT_W(2)) u_dut_w2 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_reg_write(id_reg_write),
        .id_write_reg(id_write_reg), .id_mem_read(id_mem_read), .ex_redirect(ex_redirect),
        .pc_write(pc_write2), .if_id_write(if_id_write2), .if_id_flush(if_id_flush2),
        .id_ex_bubble(id_ex_bubble2), .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall_count(stall_count2)
    );

    assign obs  = {pc_write, if_id_write, if_id_flush, id_ex_bubble, fwd_a, fwd_b};
    assign obs2 = {pc_write2, if_id_write2, if_id_flush2, id_ex_bubble2, fwd_a2, fwd_b2};

    // Model: one instruction record per downstream stage, index 0=EX, 1=MEM, 2=WB.
    typedef struct packed {
        bit       valid;
        bit       rw;
        bit [4:0] wr;
        bit       mr;
        bit [4:0] rs;
        bit [4:0] rt;
        bit       urs;
        bit       urt;
    } instr_t;

    instr_t      pipe [3];
    logic [15:0] m_cnt16;
    logic [1:0]  m_cnt2;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic bit produces(instr_t s);
        return s.valid && s.rw && (s.wr != 0);
    endfunction

    function automatic bit model_stall();
        bit needs;
        if (!reset) return 1'b0;
        needs = (id_use_rs && (pipe[0].wr == id_rs)) || (id_use_rt && (pipe[0].wr == id_rt));
        return id_valid && produces(pipe[0]) && pipe[0].mr && needs && !ex_redirect;
    endfunction

    // Youngest producer wins; a load still in MEM cannot supply data and is skipped.
    function automatic logic [1:0] model_fwd(bit [4:0] r, bit u);
        for (int s = 1; s <= 2; s++) begin
            if (u && produces(pipe[s]) && (pipe[s].wr == r)) begin
                if (s == 2) return 2'b01;
                if (!pipe[s].mr) return 2'b10;
            end
        end
        return 2'b00;
    endfunction

    function automatic logic [7:0] model_out();
        bit st;
        if (!reset) return 8'b1100_0000;
        st = model_stall();
        return {~st, ~st, ex_redirect, st | ex_redirect,
                model_fwd(pipe[0].rs, pipe[0].urs), model_fwd(pipe[0].rt, pipe[0].urt)};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        m_cnt16 = '0;
        m_cnt2  = '0;
    endtask

    task automatic model_advance();
        bit     st;
        instr_t nx;
        if (!reset) return;
        st = model_stall();
        nx = '{valid: id_valid, rw: id_reg_write, wr: id_write_reg, mr: id_mem_read,
               rs: id_rs, rt: id_rt, urs: id_use_rs, urt: id_use_rt};
        if (st || ex_redirect) nx = '0;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = nx;
        if (st && m_cnt16 != 16'hFFFF) m_cnt16 = m_cnt16 + 1'b1;
        if (st && m_cnt2 != 2'b11)     m_cnt2  = m_cnt2 + 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic set_id(bit v, bit [4:0] rs, bit urs, bit [4:0] rt, bit urt,
                          bit rw, bit [4:0] wr, bit mr, bit redir);
        id_valid     = v;
        id_rs        = urs ? rs : 5'd0;
        id_use_rs    = urs;
        id_rt        = urt ? rt : 5'd0;
        id_use_rt    = urt;
        id_reg_write = rw;
        id_write_reg = wr;
        id_mem_read  = mr;
        ex_redirect  = redir;
    endtask

    task automatic set_nop();        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);      endtask
    task automatic set_lw_t0();      set_id(1, 16, 1, 0, 0, 1, 8, 1, 0);     endtask
    task automatic set_add_t1(bit r); set_id(1, 8, 1, 10, 1, 1, 9, 0, r);    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_nop();
        #1 model_clear();
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_add_t1(1'b1);
        model_clear();
        #1;
        n_vec++;
        if (obs !== 8'b1100_0000) begin n_err++; $display("FAIL reset_outputs: got %b need %b", obs, 8'b1100_0000); end
        n_vec++;
        if (stall_count !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d need 0", stall_count); end
        @(posedge clk);
        #1 reset = 1'b1;
        set_nop();
        #1;
        n_vec++;
        if (obs !== 8'b1100_0000) begin n_err++; $display("FAIL reset_release: got %b need %b", obs, 8'b1100_0000); end
        n_vec++;
        if (stall_count2 !== 2'd0) begin n_err++; $display("FAIL reset_count_w2: got %0d need 0", stall_count2); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_lw_t0(); #1;
        n_vec++;
        if (obs !== 8'b1100_0000) begin n_err++; $display("FAIL lu_lw_in_id: got %b need %b", obs, 8'b1100_0000); end
        tick();
        set_add_t1(1'b0); #1;
        n_vec++;
        if (obs !== 8'b0001_0000) begin n_err++; $display("FAIL lu_stall: got %b need %b", obs, 8'b0001_0000); end
        tick();
        n_vec++;
        if (obs !== 8'b1100_0000) begin n_err++; $display("FAIL lu_single_stall: got %b need %b", obs, 8'b1100_0000); end
        tick();
        set_nop(); #1;
        n_vec++;
        if (obs !== 8'b1100_0100) begin n_err++; $display("FAIL lu_fwd_wb: got %b need %b", obs, 8'b1100_0100); end
        n_vec++;
        if (stall_count !== 16'd1) begin n_err++; $display("FAIL lu_count: got %0d need 1", stall_count); end
    endtask

    task automatic test_forward_mem();
        do_reset();
        set_id(1, 9, 1, 10, 1, 1, 8, 0, 0);
        tick();
        set_id(1, 8, 1, 8, 1, 1, 11, 0, 0); #1;
        n_vec++;
        if (obs !== 8'b1100_0000) begin n_err++; $display("FAIL fwd_mem_nostall: got %b need %b", obs, 8'b1100_0000); end
        tick();
        set_nop(); #1;
        n_vec++;
        if (obs !== 8'b1100_1010) begin n_err++; $display("FAIL fwd_mem_ab: got %b need %b", obs, 8'b1100_1010); end
        n_vec++;
        if (stall_count !== 16'd0) begin n_err++; $display("FAIL fwd_mem_count: got %0d need 0", stall_count); end
    endtask

    task automatic test_mem_over_wb();
        do_reset();
        set_id(1, 9, 1, 10, 1, 1, 8, 0, 0);  tick();
        set_id(1, 17, 1, 18, 1, 1, 8, 0, 0); tick();
        set_id(1, 8, 1, 9, 1, 1, 12, 0, 0);  tick();
        set_nop(); #1;
        n_vec++;
        if (obs !== 8'b1100_1000) begin n_err++; $display("FAIL mem_over_wb: got %b need %b", obs, 8'b1100_1000); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        set_id(1, 16, 1, 0, 0, 1, 0, 1, 0); tick();
        set_id(1, 0, 1, 0, 1, 1, 9, 0, 0); #1;
        n_vec++;
        if (obs !== 8'b1100_0000) begin n_err++; $display("FAIL zero_nostall: got %b need %b", obs, 8'b1100_0000); end
        tick();
        set_nop(); #1;
        n_vec++;
        if (obs !== 8'b1100_0000) begin n_err++; $display("FAIL zero_nofwd: got %b need %b", obs, 8'b1100_0000); end
        n_vec++;
        if (stall_count !== 16'd0) begin n_err++; $display("FAIL zero_count: got %0d need 0", stall_count); end
    endtask

    task automatic test_redirect_priority();
        do_reset();
        set_lw_t0(); tick();
        set_add_t1(1'b1); #1;
        n_vec++;
        if (obs !== 8'b1111_0000) begin n_err++; $display("FAIL redir_outputs: got %b need %b", obs, 8'b1111_0000); end
        tick();
        n_vec++;
        if (stall_count !== 16'd0) begin n_err++; $display("FAIL redir_count: got %0d need 0", stall_count); end
        set_add_t1(1'b0); #1;
        n_vec++;
        if (obs !== 8'b1100_0000) begin n_err++; $display("FAIL redir_after: got %b need %b", obs, 8'b1100_0000); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            set_lw_t0(); tick();
            set_add_t1(1'b0); #1;
            n_vec++;
            if (obs !== 8'b0001_0000) begin n_err++; $display("FAIL sat_stall%0d: got %b need %b", k, obs, 8'b0001_0000); end
            tick();
        end
        n_vec++;
        if (stall_count2 !== 2'd3) begin n_err++; $display("FAIL sat_w2: got %0d need 3", stall_count2); end
        n_vec++;
        if (stall_count !== 16'd5) begin n_err++; $display("FAIL sat_w16: got %0d need 5", stall_count); end
        set_lw_t0(); tick();
        set_add_t1(1'b0); #1;
        reset = 1'b0;
        #1;
        model_clear();
        n_vec++;
        if (obs !== 8'b1100_0000) begin n_err++; $display("FAIL midstall_reset: got %b need %b", obs, 8'b1100_0000); end
        n_vec++;
        if (stall_count2 !== 2'd0) begin n_err++; $display("FAIL midstall_count: got %0d need 0", stall_count2); end
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_vec++;
        if (obs !== 8'b1100_0000) begin n_err++; $display("FAIL post_reset_nostall: got %b need %b", obs, 8'b1100_0000); end
    endtask

    task automatic test_random();
        logic [7:0] exp;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            set_id($urandom_range(0, 7) != 0,
                   5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                   5'($urandom_range(0, 3)), $urandom_range(0, 1) != 0,
                   $urandom_range(0, 4) != 0, 5'($urandom_range(0, 3)),
                   $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
            #1;
            exp = model_out();
            n_vec++;
            if (obs !== exp) begin n_err++; $display("FAIL rand_out c=%0d: got %b need %b", c, obs, exp); end
            n_vec++;
            if (obs2 !== exp) begin n_err++; $display("FAIL rand_out_w2 c=%0d: got %b need %b", c, obs2, exp); end
            n_vec++;
            if (stall_count !== m_cnt16) begin n_err++; $display("FAIL rand_cnt c=%0d: got %0d need %0d", c, stall_count, m_cnt16); end
            n_vec++;
            if (stall_count2 !== m_cnt2) begin n_err++; $display("FAIL rand_cnt_w2 c=%0d: got %0d need %0d", c, stall_count2, m_cnt2); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward_mem();
        test_mem_over_wb();
        test_zero_reg();
        test_redirect_priority();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
